multiplier_control_taint_gen: RTL and testbench
===============================================

# multiplier_control_taint_gen

Parametrised, taint-tracking control FSM for the shift-add sequential multiplier datapath. For every multiplier bit it issues load/clear/shift strobes, holds a completion handshake until the consumer acknowledges it, and carries a one-bit taint for every control output. Taint is tracked per multiplier bit, and the control taint is re-based at the start of each transaction. It sits between the top-level requester and the multiplier datapath (product/multiplier/multiplicand registers).

## Interface
- WIDTH, 8, operand width; ≥2. CW = $clog2(WIDTH).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start / start_t  in  1 / 1  transaction request and its taint.
- done_ack / done_ack_t  in  1 / 1  consumer acknowledge of productDone, and its taint.
- multiplierReg / multiplierReg_t  in  WIDTH / WIDTH  multiplier value from the datapath, and its per-bit taint.
- mdld, mrld, rsclear, rsload, rsshr  out  1 each  datapath strobes, each with a matching 1-bit _t output.
- productDone / productDone_t  out  1 / 1  result valid, and its taint.
- busy / busy_t  out  1 / 1  transaction in progress, and its taint.
- bitIndex / bitIndex_t  out  CW / 1  current bit counter, and its taint.

## Operation
- States and encodings: IDLE=0, INIT=1, TEST=2, ADD=3, SHIFT=4, DONE=5. Codes 6–7 go to IDLE on the next cycle.
- Outputs are Moore, decoded from state only:
  - INIT: mdld, mrld and rsclear are 1.
  - ADD: rsload is 1.
  - SHIFT: rsshr is 1.
  - DONE: productDone is 1.
  - busy is 1 in every state except IDLE.
  - All other outputs are 0.
- Transitions:
  - IDLE: go to INIT if start, else stay in IDLE.
  - INIT: go to TEST and clear the counter to 0.
  - TEST: go to ADD if multiplierReg[cnt], else go to SHIFT. TEST has no strobes.
  - ADD: go to SHIFT.
  - SHIFT: cnt increments. Go to DONE if cnt == WIDTH-1 (evaluated before the increment), else go to TEST.
  - DONE: go to IDLE if done_ack, else stay in DONE.
- Counter width:
  - cnt never exceeds WIDTH-1 while in TEST.
  - The final increment in SHIFT wraps modulo 2^CW; its value is don't-care until INIT clears it.
- start outside IDLE is ignored. done_ack outside DONE is ignored.
- Taint rules:
  - state_t is the control taint. Every control output's _t, including busy_t and productDone_t, equals state_t in every state, whether the output value is 0 or 1.
  - Next state_t by state:
    - IDLE: start_t. This re-bases taint per transaction and discards prior taint.
    - INIT, ADD: state_t.
    - TEST: state_t | multiplierReg_t[cnt] | cnt_t.
    - SHIFT: state_t | cnt_t.
    - DONE: state_t | done_ack_t.
  - cnt_t: INIT loads state_t; SHIFT loads cnt_t | state_t; all other states hold it. bitIndex_t = cnt_t.
- Reset (rst_n low, any time, including mid-transaction):
  - State goes to IDLE immediately; cnt=0, state_t=0, cnt_t=0.
  - All outputs are therefore 0, with all _t outputs 0.
  - The first transition after release occurs at the first rising edge with rst_n high.

## Timing
- start is sampled at edge 0. INIT is active in cycle 1 and TEST in cycle 2.
- Per bit: 3 cycles if the bit is 1 (TEST, ADD, SHIFT); 2 cycles if the bit is 0 (TEST, SHIFT).
- DONE is entered at cycle 2 + 2·WIDTH + popcount(multiplierReg).
- productDone is held until done_ack is sampled high. IDLE follows on the next cycle, and busy drops in that same cycle.
- A new start is accepted in the first IDLE cycle (back-to-back transactions; minimum one IDLE cycle between them).
- multiplierReg must be stable from INIT+1 until DONE; the datapath guarantees this.
- Taint entering via TEST appears on the _t outputs in the following cycle, and persists until the next IDLE evaluation.

## Test plan
- WIDTH=4, multiplierReg=4'b1011, all taints 0, start pulse at cycle 0:
  - INIT in cycle 1; 3 rsload pulses and 4 rsshr pulses.
  - productDone=1 from cycle 13; every _t output stays 0.
- WIDTH=4, multiplierReg=0:
  - No rsload; DONE at cycle 10.
  - done_ack withheld 5 cycles -> productDone and busy held high; IDLE the cycle after ack.
- WIDTH=4, multiplierReg=4'b1011, multiplierReg_t=4'b0100:
  - All _t outputs are 0 until the TEST of bit 2.
  - They are 1 from the next cycle through DONE, and return to 0 when IDLE is entered with start_t=0.
- IDLE, start=0, start_t=1 for one cycle:
  - All outputs stay 0; all _t outputs are 1 for exactly one cycle, then 0.
- rst_n driven low asynchronously during ADD:
  - rsload, busy and every _t output drop before the next edge.
  - After release, a new start completes normally with the correct cycle count.
- start re-asserted during SHIFT and DONE:
  - Ignored; no extra INIT.
  - Next INIT occurs only after DONE→IDLE; WIDTH=8 with multiplierReg=8'hFF gives DONE at cycle 26.

Source files
------------

// File: rtl/multiplier_control_taint_gen_if.sv
// Control/handshake bundle between requester, datapath and the multiplier controller.
interface multiplier_control_taint_gen_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH);

  // Requester / datapath inputs to the controller
  logic             start;
  logic             start_t;
  logic             done_ack;
  logic             done_ack_t;
  logic [WIDTH-1:0] multiplierReg;
  logic [WIDTH-1:0] multiplierReg_t;

  // Controller outputs toward the datapath and requester
  logic             mdld;
  logic             mdld_t;
  logic             mrld;
  logic             mrld_t;
  logic             rsclear;
  logic             rsclear_t;
  logic             rsload;
  logic             rsload_t;
  logic             rsshr;
  logic             rsshr_t;
  logic             productDone;
  logic             productDone_t;
  logic             busy;
  logic             busy_t;
  logic [CW-1:0]    bitIndex;
  logic             bitIndex_t;

  // Requester/datapath side
  modport master (
    output start, start_t, done_ack, done_ack_t, multiplierReg, multiplierReg_t,
    input  mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t,
           rsshr, rsshr_t, productDone, productDone_t, busy, busy_t,
           bitIndex, bitIndex_t
  );

  // Controller side
  modport slave (
    input  start, start_t, done_ack, done_ack_t, multiplierReg, multiplierReg_t,
    output mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t,
           rsshr, rsshr_t, productDone, productDone_t, busy, busy_t,
           bitIndex, bitIndex_t
  );
endinterface

// File: rtl/multiplier_control_taint_gen.sv
// Shift-add multiplier control FSM with one-bit taint per control output.
// Strobes are Moore outputs; they are registered from the next-state decode so
// they line up exactly with the state register.
module multiplier_control_taint_gen #(
  parameter int unsigned WIDTH = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  multiplier_control_taint_gen_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          state_t;
  logic          state_t_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          cnt_t;
  logic          cnt_t_nxt;

  logic          mdld_q, mrld_q, rsclear_q, rsload_q, rsshr_q, done_q, busy_q;
  logic          mdld_nxt, mrld_nxt, rsclear_nxt, rsload_nxt, rsshr_nxt, done_nxt, busy_nxt;

  logic          bit_val;
  logic          bit_t;
  logic          last_bit;

  // Current multiplier bit and whether this is the final bit position
  assign bit_val  = bus.multiplierReg[cnt];
  assign bit_t    = bus.multiplierReg_t[cnt];
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Next-state, counter and taint propagation
  always_comb begin
    state_nxt   = state;
    state_t_nxt = state_t;
    cnt_nxt     = cnt;
    cnt_t_nxt   = cnt_t;
    case (state)
      S_IDLE: begin
        // Taint is re-based here: anything carried from the last transaction is dropped.
        state_t_nxt = bus.start_t;
        if (bus.start) begin
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        cnt_nxt   = '0;
        cnt_t_nxt = state_t;
        state_nxt = S_TEST;
      end
      S_TEST: begin
        state_t_nxt = state_t | bit_t | cnt_t;
        state_nxt   = bit_val ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // Final increment wraps; the value is reloaded by INIT before any reuse.
        cnt_nxt     = cnt + CW'(1);
        cnt_t_nxt   = cnt_t | state_t;
        state_t_nxt = state_t | cnt_t;
        state_nxt   = last_bit ? S_DONE : S_TEST;
      end
      S_DONE: begin
        state_t_nxt = state_t | bus.done_ack_t;
        if (bus.done_ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore strobe decode of the state being entered
  always_comb begin
    mdld_nxt    = 1'b0;
    mrld_nxt    = 1'b0;
    rsclear_nxt = 1'b0;
    rsload_nxt  = 1'b0;
    rsshr_nxt   = 1'b0;
    done_nxt    = 1'b0;
    busy_nxt    = 1'b0;
    case (state_nxt)
      S_INIT: begin
        mdld_nxt    = 1'b1;
        mrld_nxt    = 1'b1;
        rsclear_nxt = 1'b1;
        busy_nxt    = 1'b1;
      end
      S_TEST: begin
        busy_nxt = 1'b1;
      end
      S_ADD: begin
        rsload_nxt = 1'b1;
        busy_nxt   = 1'b1;
      end
      S_SHIFT: begin
        rsshr_nxt = 1'b1;
        busy_nxt  = 1'b1;
      end
      S_DONE: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      S_IDLE: begin
        busy_nxt = 1'b0;
      end
      default: begin
        // Illegal codes still count as non-IDLE for one cycle.
        busy_nxt = 1'b1;
      end
    endcase
  end

  // State, counter, taint and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      state_t   <= 1'b0;
      cnt       <= '0;
      cnt_t     <= 1'b0;
      mdld_q    <= 1'b0;
      mrld_q    <= 1'b0;
      rsclear_q <= 1'b0;
      rsload_q  <= 1'b0;
      rsshr_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      state_t   <= state_t_nxt;
      cnt       <= cnt_nxt;
      cnt_t     <= cnt_t_nxt;
      mdld_q    <= mdld_nxt;
      mrld_q    <= mrld_nxt;
      rsclear_q <= rsclear_nxt;
      rsload_q  <= rsload_nxt;
      rsshr_q   <= rsshr_nxt;
      done_q    <= done_nxt;
      busy_q    <= busy_nxt;
    end
  end

  // Output mapping; every control taint is the single control-path taint bit
  assign bus.mdld          = mdld_q;
  assign bus.mrld          = mrld_q;
  assign bus.rsclear       = rsclear_q;
  assign bus.rsload        = rsload_q;
  assign bus.rsshr         = rsshr_q;
  assign bus.productDone   = done_q;
  assign bus.busy          = busy_q;
  assign bus.bitIndex      = cnt;

  assign bus.mdld_t        = state_t;
  assign bus.mrld_t        = state_t;
  assign bus.rsclear_t     = state_t;
  assign bus.rsload_t      = state_t;
  assign bus.rsshr_t       = state_t;
  assign bus.productDone_t = state_t;
  assign bus.busy_t        = state_t;
  assign bus.bitIndex_t    = cnt_t;

endmodule

// File: tb/tb_multiplier_control_taint_gen.sv
// Scoreboard bench: stimulus walks each transaction bit by bit and queues the
// expected per-cycle outputs; a monitor pops and compares on every falling edge.
module tb_multiplier_control_taint_gen;
  localparam int unsigned WIDTH   = 4;
  localparam int unsigned CW      = $clog2(WIDTH);
  localparam int unsigned CNT_MOD = 1 << CW;

  localparam int P_IDLE  = 0;
  localparam int P_INIT  = 1;
  localparam int P_TEST  = 2;
  localparam int P_ADD   = 3;
  localparam int P_SHIFT = 4;
  localparam int P_DONE  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiplier_control_taint_gen_if #(.WIDTH(WIDTH)) bus ();
  multiplier_control_taint_gen #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // strobes = {mdld, mrld, rsclear, rsload, rsshr, productDone, busy}
  typedef struct packed {
    logic [6:0]    strobes;
    logic [CW-1:0] idx;
    logic [6:0]    t;
    logic          idx_t;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt    = 0;
  logic m_ct     = 1'b0;

  function automatic obs_t expect_obs(int ph, int idx, logic idx_t, logic t);
    obs_t e;
    case (ph)
      P_INIT:  e.strobes = 7'b1110001;
      P_TEST:  e.strobes = 7'b0000001;
      P_ADD:   e.strobes = 7'b0001001;
      P_SHIFT: e.strobes = 7'b0000101;
      P_DONE:  e.strobes = 7'b0000011;
      default: e.strobes = 7'b0000000;
    endcase
    e.idx   = CW'(idx);
    e.t     = {7{t}};
    e.idx_t = idx_t;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.strobes = {bus.mdld, bus.mrld, bus.rsclear, bus.rsload, bus.rsshr, bus.productDone, bus.busy};
    a.idx     = bus.bitIndex;
    a.t       = {bus.mdld_t, bus.mrld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t,
                 bus.productDone_t, bus.busy_t};
    a.idx_t   = bus.bitIndex_t;
    return a;
  endfunction

  task automatic check_obs(input string name, input obs_t e);
    obs_t a;
    a = sample();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got strobes=%b idx=%0d t=%b idx_t=%b, want strobes=%b idx=%0d t=%b idx_t=%b",
               name, $time, a.strobes, a.idx, a.t, a.idx_t, e.strobes, e.idx, e.t, e.idx_t);
    end
  endtask

  // Monitor: one expected record per cycle while out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow @%0t: got empty queue, want a record", $time);
        end else begin
          check_obs("cycle", exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic st, input logic a, input logic at);
    bus.start      = s;
    bus.start_t    = st;
    bus.done_ack   = a;
    bus.done_ack_t = at;
  endtask

  // Inputs that must be ignored while the controller is busy outside DONE
  task automatic noise_drive(input logic noise);
    drive(noise ? rb() : 1'b0, rb(), noise ? rb() : 1'b0, rb());
  endtask

  task automatic idle_cycle(input logic st_t);
    drive(1'b0, st_t, rb(), rb());
    exp_q.push_back(expect_obs(P_IDLE, m_cnt, m_ct, st_t));
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_obs("reset_hold", expect_obs(P_IDLE, 0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cnt = 0;
    m_ct  = 1'b0;
    exp_q.push_back(expect_obs(P_IDLE, 0, 1'b0, 1'b0));
  endtask

  // Called in the first IDLE cycle; returns in the first IDLE cycle afterwards.
  task automatic run_txn(input logic [WIDTH-1:0] mr, input logic [WIDTH-1:0] mrt,
                         input logic st_t, input int ack_dly, input logic abort,
                         input logic noise);
    logic t, ct, tn, a;
    int   wrap_cnt;
    wrap_cnt            = int'(WIDTH % CNT_MOD);
    bus.multiplierReg   = mr;
    bus.multiplierReg_t = mrt;
    drive(1'b1, st_t, rb(), rb());
    t = st_t;
    exp_q.push_back(expect_obs(P_INIT, m_cnt, m_ct, t));
    step();
    noise_drive(noise);
    ct = t;
    exp_q.push_back(expect_obs(P_TEST, 0, ct, t));
    step();
    for (int i = 0; i < int'(WIDTH); i++) begin
      noise_drive(noise);
      tn = t | mrt[i] | ct;
      if (mr[i]) begin
        exp_q.push_back(expect_obs(P_ADD, i, ct, tn));
        step();
        t = tn;
        if (abort) begin
          n_checks++;
          if (bus.rsload !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_add @%0t: got rsload=%b busy=%b, want 1 1", $time, bus.rsload, bus.busy);
          end
          #2;
          rst_n = 1'b0;
          #1;
          check_obs("reset_async", expect_obs(P_IDLE, 0, 1'b0, 1'b0));
          do_reset();
          return;
        end
        noise_drive(noise);
        exp_q.push_back(expect_obs(P_SHIFT, i, ct, t));
        step();
      end else begin
        exp_q.push_back(expect_obs(P_SHIFT, i, ct, tn));
        step();
        t = tn;
      end
      noise_drive(noise);
      tn = t | ct;
      ct = ct | t;
      t  = tn;
      if (i < int'(WIDTH) - 1) exp_q.push_back(expect_obs(P_TEST, i + 1, ct, t));
      else                     exp_q.push_back(expect_obs(P_DONE, wrap_cnt, ct, t));
      step();
    end
    for (int k = 0; k <= ack_dly; k++) begin
      a = rb();
      drive(noise ? rb() : 1'b0, rb(), (k == ack_dly), a);
      t = t | a;
      exp_q.push_back(expect_obs((k < ack_dly) ? P_DONE : P_IDLE, wrap_cnt, ct, t));
      step();
    end
    m_cnt = wrap_cnt;
    m_ct  = ct;
  endtask

  initial begin
    logic [WIDTH-1:0] mr, mrt;
    bus.multiplierReg   = '0;
    bus.multiplierReg_t = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    run_txn(4'b1011, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    run_txn(4'b0000, 4'b0000, 1'b0, 5, 1'b0, 1'b1);
    run_txn(4'b1011, 4'b0100, 1'b0, 2, 1'b0, 1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    run_txn(4'b1011, 4'b0000, 1'b0, 0, 1'b1, 1'b0);
    idle_cycle(1'b0);
    run_txn(4'b1011, 4'b0000, 1'b0, 0, 1'b0, 1'b1);
    run_txn(4'b1111, 4'b0000, 1'b1, 1, 1'b0, 1'b1);
    idle_cycle(1'b0);

    for (int n = 0; n < 40; n++) begin
      mr  = WIDTH'($urandom);
      mrt = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
      run_txn(mr, mrt, ($urandom_range(0, 3) == 0), $urandom_range(0, 4), 1'b0, rb());
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle(rb());
    end

    idle_cycle(1'b0);
    idle_cycle(1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
